// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, owner codes and
// a width helper for the latency and streak counters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Width needed to hold 0..v; never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and memory bus of the arbiter.
// slave = arbiter view, master = processor/memory environment view.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_streak_cnt.sv
// Saturating count of data grants made while a fetch is waiting; raises
// fetch priority once the count reaches MAX_STREAK.
module mem_arbiter_streak_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_i_i,
    input  logic grant_d_i,
    input  logic i_req_i,
    output logic fetch_pri_o
);
    localparam int SW = cnt_width(MAX_STREAK);
    localparam logic [SW-1:0] SAT = SW'(MAX_STREAK);

    logic [SW-1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (grant_i_i) begin
            streak_d = '0;
        end else if (grant_d_i) begin
            if (!i_req_i)
                streak_d = '0;
            else if (streak_q != SAT)
                streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) streak_q <= '0;
        else      streak_q <= streak_d;
    end

    assign fetch_pri_o = (streak_q == SAT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single fixed-latency memory between the fetch and data ports:
// one transaction at a time, IDLE -> WAIT -> DONE, with a one-cycle done pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 3,
    parameter int AW         = 16,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic          err
);
    localparam int   CNT_W   = cnt_width(MEM_LAT);
    localparam logic BAD_CFG = (MEM_LAT < 1) || (MAX_STREAK < 1);

    state_t         state_q;
    owner_t         owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic           busy_q, err_q;
    logic           i_done_q, d_done_q;
    logic [DW-1:0]  i_rdata_q, d_rdata_q;
    logic           mem_en_q, mem_wr_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_wdata_q;

    logic fetch_pri, grant_i, grant_d, owner_req;

    always_comb begin
        grant_i   = (state_q == ST_IDLE) && bus.i_req && (!bus.d_req || fetch_pri);
        grant_d   = (state_q == ST_IDLE) && bus.d_req && !grant_i;
        owner_req = (owner_q == OWN_D) ? bus.d_req : bus.i_req;
    end

    mem_arbiter_streak_cnt #(.MAX_STREAK(MAX_STREAK)) u_arb_streak_cnt (
        .clk         (clk),
        .rst         (rst),
        .grant_i_i   (grant_i),
        .grant_d_i   (grant_d),
        .i_req_i     (bus.i_req),
        .fetch_pri_o (fetch_pri)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            err_q       <= BAD_CFG;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_i || grant_d) begin
                        owner_q     <= grant_d ? OWN_D : OWN_I;
                        mem_addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                        mem_wdata_q <= grant_d ? bus.d_wdata : '0;
                        mem_wr_q    <= grant_d && bus.d_wr;
                        mem_en_q    <= 1'b1;
                        cnt_q       <= CNT_W'(MEM_LAT);
                        busy_q      <= 1'b1;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!owner_req) err_q <= 1'b1;
                    if (cnt_q == '0) begin
                        if (owner_q == OWN_I) begin
                            i_rdata_q <= bus.mem_rdata;
                            i_done_q  <= 1'b1;
                        end else begin
                            if (!mem_wr_q) d_rdata_q <= bus.mem_rdata;
                            d_done_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Requests must stay up through the done cycle.
                    if (!owner_req) err_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.i_done    = i_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule
